// File: rtl/risc16_pkg.sv
// Shared register-file geometry and the writeback entry type for the risc16 core.
// Also holds the read-port bypass helper used by the writeback stage.
package risc16_pkg;

    localparam int REG_W      = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_W-1:0]      data;
    } wb_entry_t;

    // r0 is hard-wired, so a read of r0 never sees the write in flight.
    function automatic logic [REG_W-1:0] bypass(
        input logic                  write_en,
        input logic [REG_ADDR_W-1:0] write_dest,
        input logic [REG_W-1:0]      write_data,
        input logic [REG_ADDR_W-1:0] rd_addr,
        input logic [REG_W-1:0]      rf_data
    );
        if (write_en && (write_dest == rd_addr) && (rd_addr != '0))
            return write_data;
        return rf_data;
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Small FIFO buffering load results until the writeback arbiter pops them.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module wb_load_fifo
    import risc16_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    entry_t      mem [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only visible once written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_entry;
    end

endmodule

// File: rtl/gpr_writeback.sv
// Writeback stage: merges ALU and queued load results into one registered GPR write,
// tracks outstanding loads per register and bypasses the in-flight write to readers.
module gpr_writeback
    import risc16_pkg::*;
#(
    parameter int LQ_DEPTH   = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_dest,
    input  logic [REG_W-1:0]      alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_dest,
    input  logic [REG_W-1:0]      ld_data,
    input  logic                  issue_ld,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  write_en,
    output logic [REG_ADDR_W-1:0] write_dest,
    output logic [REG_W-1:0]      write_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_1,
    input  logic [REG_ADDR_W-1:0] rd_addr_2,
    input  logic [REG_W-1:0]      rf_data_1,
    input  logic [REG_W-1:0]      rf_data_2,
    output logic [REG_W-1:0]      fwd_data_1,
    output logic [REG_W-1:0]      fwd_data_2
);

    logic                  lq_push;
    logic                  lq_pop;
    logic                  lq_full;
    logic                  lq_empty;
    wb_entry_t             lq_head;
    wb_entry_t             ld_entry;
    wb_entry_t             sel_entry;
    logic                  sel_valid;
    logic                  starve;
    logic                  alu_take;
    logic [3:0]            wait_cnt_reg;
    logic [3:0]            wait_cnt_next;
    logic [NUM_REGS-1:0]   pending_reg;
    logic [NUM_REGS-1:0]   pending_next;
    logic                  write_en_reg;
    logic [REG_ADDR_W-1:0] write_dest_reg;
    logic [REG_W-1:0]      write_data_reg;

    assign ld_entry = '{dest: ld_dest, data: ld_data};
    assign lq_push  = ld_valid && !lq_full;
    assign ld_ready = !lq_full;

    wb_load_fifo #(
        .DEPTH   (LQ_DEPTH),
        .entry_t (wb_entry_t)
    ) u_load_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (lq_push),
        .push_entry (ld_entry),
        .pop        (lq_pop),
        .full       (lq_full),
        .empty      (lq_empty),
        .head       (lq_head)
    );

    // ALU has priority until the queue head has waited STARVE_MAX cycles.
    always_comb begin
        starve        = !lq_empty && (wait_cnt_reg >= 4'(STARVE_MAX));
        alu_ready     = !starve;
        alu_take      = alu_valid && !starve;
        lq_pop        = !alu_take && !lq_empty;
        sel_valid     = alu_take || lq_pop;
        sel_entry     = alu_take ? '{dest: alu_dest, data: alu_data} : lq_head;
        wait_cnt_next = wait_cnt_reg;
        if (lq_empty || lq_pop)
            wait_cnt_next = '0;
        else if (wait_cnt_reg != 4'hF)
            wait_cnt_next = wait_cnt_reg + 4'd1;
    end

    // A load committing and a reissue to the same register: the new set survives.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            if (gi == 0) begin : g_r0
                assign pending_next[gi] = 1'b0;
            end else begin : g_rn
                logic set_bit;
                logic clr_bit;
                assign set_bit = issue_ld && (issue_dest == REG_ADDR_W'(gi));
                assign clr_bit = lq_pop && (lq_head.dest == REG_ADDR_W'(gi));
                assign pending_next[gi] = set_bit || (pending_reg[gi] && !clr_bit);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg   <= '0;
            pending_reg    <= '0;
            write_en_reg   <= 1'b0;
            write_dest_reg <= '0;
            write_data_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            pending_reg  <= pending_next;
            write_en_reg <= sel_valid && (sel_entry.dest != '0);
            if (sel_valid) begin
                write_dest_reg <= sel_entry.dest;
                write_data_reg <= sel_entry.data;
            end
        end
    end

    assign pending    = pending_reg;
    assign write_en   = write_en_reg;
    assign write_dest = write_dest_reg;
    assign write_data = write_data_reg;
    assign fwd_data_1 = bypass(write_en_reg, write_dest_reg, write_data_reg, rd_addr_1, rf_data_1);
    assign fwd_data_2 = bypass(write_en_reg, write_dest_reg, write_data_reg, rd_addr_2, rf_data_2);

endmodule

// File: tb/tb_gpr_writeback.sv
// Bench for gpr_writeback: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based model of the stage.
module tb_gpr_writeback;

    localparam int LQ     = 2;
    localparam int STARVE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid, ld_valid, issue_ld;
    logic        alu_ready, ld_ready, write_en;
    logic [2:0]  alu_dest, ld_dest, issue_dest, write_dest, rd_addr_1, rd_addr_2;
    logic [15:0] alu_data, ld_data, write_data, rf_data_1, rf_data_2, fwd_data_1, fwd_data_2;
    logic [7:0]  pending;

    gpr_writeback #(.LQ_DEPTH(LQ), .STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
        .issue_ld(issue_ld), .issue_dest(issue_dest), .pending(pending),
        .write_en(write_en), .write_dest(write_dest), .write_data(write_data),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
        .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  d;
        logic [15:0] v;
    } ent_t;

    // Model state: what the stage holds after the most recent clock edge.
    ent_t        q[$];
    int          mwait;
    logic [7:0]  mpend;
    logic        m_we;
    logic [2:0]  m_wd;
    logic [15:0] m_wdata;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [2:0]  commit_d[$];
    logic [15:0] commit_v[$];
    bit          aa, la;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mwait   = 0;
        mpend   = '0;
        m_we    = 1'b0;
        m_wd    = '0;
        m_wdata = '0;
    endtask

    task automatic clear_inputs();
        alu_valid = 0; alu_dest = 0; alu_data = 0;
        ld_valid = 0; ld_dest = 0; ld_data = 0;
        issue_ld = 0; issue_dest = 0;
        rd_addr_1 = 0; rd_addr_2 = 0; rf_data_1 = 0; rf_data_2 = 0;
    endtask

    // One cycle: compare outputs against the model, advance the model, cross the edge.
    task automatic step(output bit alu_acc, output bit ld_acc);
        logic        exp_ar, exp_lr, nonempty, popped;
        logic [7:0]  clr, set;
        logic [15:0] ef1, ef2;
        ent_t        e;
        #1;
        exp_ar = !(q.size() != 0 && mwait >= STARVE);
        exp_lr = (q.size() < LQ);
        ef1 = (m_we && m_wd == rd_addr_1 && rd_addr_1 != 0) ? m_wdata : rf_data_1;
        ef2 = (m_we && m_wd == rd_addr_2 && rd_addr_2 != 0) ? m_wdata : rf_data_2;
        chk("alu_ready", alu_ready, exp_ar);
        chk("ld_ready", ld_ready, exp_lr);
        chk("pending", pending, mpend);
        chk("write_en", write_en, m_we);
        chk("write_dest", write_dest, m_wd);
        chk("write_data", write_data, m_wdata);
        chk("fwd_data_1", fwd_data_1, ef1);
        chk("fwd_data_2", fwd_data_2, ef2);

        alu_acc  = alu_valid && exp_ar;
        ld_acc   = ld_valid && exp_lr;
        nonempty = (q.size() != 0);
        popped   = 1'b0;
        clr      = '0;
        set      = '0;
        if (alu_acc) begin
            assert (!(alu_dest != 0 && mpend[alu_dest]))
                else $error("illegal ALU write to pending r%0d", alu_dest);
            m_we = (alu_dest != 0); m_wd = alu_dest; m_wdata = alu_data;
        end else if (nonempty) begin
            e = q.pop_front();
            m_we = (e.d != 0); m_wd = e.d; m_wdata = e.v;
            if (e.d != 0) clr[e.d] = 1'b1;
            popped = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        if (!nonempty || popped) mwait = 0;
        else if (mwait < 15) mwait++;
        if (issue_ld && issue_dest != 0) begin
            assert (!(mpend[issue_dest] && !clr[issue_dest]))
                else $error("illegal issue_ld to pending r%0d", issue_dest);
            set[issue_dest] = 1'b1;
        end
        mpend = (mpend & ~clr) | set;
        if (ld_acc) q.push_back('{ld_dest, ld_data});

        @(posedge clk);
        @(negedge clk);
        if (write_en) begin
            commit_d.push_back(write_dest);
            commit_v.push_back(write_data);
        end
    endtask

    logic [15:0] exp_ord[3];
    logic [2:0]  exp_dst[3];
    logic [2:0]  outq[$];

    initial begin
        int k;
        bit done;
        logic [2:0] d;
        logic [15:0] got_v[$];
        logic [2:0]  got_d[$];

        clear_inputs();
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_write_en", write_en, 0);
        chk("rst_write_dest", write_dest, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_pending", pending, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_ld_ready", ld_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: reset with two queued loads outstanding
        issue_ld = 1; issue_dest = 2;
        step(aa, la);
        issue_dest = 3; ld_valid = 1; ld_dest = 2; ld_data = 16'h0202;
        alu_valid = 1; alu_dest = 1; alu_data = 16'h0001;
        step(aa, la);
        issue_ld = 0; ld_dest = 3; ld_data = 16'h0303;
        step(aa, la);
        clear_inputs();
        #1;
        chk("t1_pending_pre", pending, 16'h000C);
        chk("t1_ld_ready_pre", ld_ready, 0);
        chk("t1_write_en_pre", write_en, 1);
        rst_n = 1'b0;
        #1;
        chk("t1_write_en", write_en, 0);
        chk("t1_pending", pending, 0);
        chk("t1_ld_ready", ld_ready, 1);
        chk("t1_alu_ready", alu_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // 2: ALU only, with bypass
        alu_valid = 1; alu_dest = 3; alu_data = 16'h1234;
        step(aa, la);
        clear_inputs();
        rd_addr_1 = 3; rf_data_1 = 16'h0000;
        #1;
        chk("t2_write_en", write_en, 1);
        chk("t2_write_dest", write_dest, 3);
        chk("t2_write_data", write_data, 16'h1234);
        chk("t2_fwd_data_1", fwd_data_1, 16'h1234);

        // 3: load waits behind a busy ALU until starved
        clear_inputs();
        issue_ld = 1; issue_dest = 5;
        step(aa, la);
        clear_inputs();
        ld_valid = 1; ld_dest = 5; ld_data = 16'hBEEF;
        alu_valid = 1; alu_dest = 1; alu_data = 16'h0100;
        step(aa, la);
        ld_valid = 0;
        for (int i = 0; i < 3; i++) begin
            alu_data = 16'h0101 + 16'(i);
            #1;
            chk("t3_alu_ready_wait", alu_ready, 1);
            step(aa, la);
        end
        #1;
        chk("t3_alu_ready_starve", alu_ready, 0);
        chk("t3_pending_set", pending, 16'h0020);
        step(aa, la);
        #1;
        chk("t3_write_en", write_en, 1);
        chk("t3_write_dest", write_dest, 5);
        chk("t3_write_data", write_data, 16'hBEEF);
        chk("t3_pending_clr", pending, 0);
        chk("t3_alu_ready_after", alu_ready, 1);
        clear_inputs();

        // 4: queue full, third load held until the first pop, order preserved
        issue_ld = 1;
        issue_dest = 4; step(aa, la);
        issue_dest = 6; step(aa, la);
        issue_dest = 7; step(aa, la);
        clear_inputs();
        commit_d.delete(); commit_v.delete();
        alu_valid = 1; alu_dest = 1; alu_data = 16'h0200;
        ld_valid = 1; ld_dest = 4; ld_data = 16'hA001;
        step(aa, la);
        ld_dest = 6; ld_data = 16'hA002;
        step(aa, la);
        ld_dest = 7; ld_data = 16'hA003;
        #1;
        chk("t4_ld_ready_full", ld_ready, 0);
        done = 0; k = -1;
        for (int i = 0; i < 20 && !done; i++) begin
            step(aa, la);
            if (la) begin done = 1; k = i; end
        end
        chk("t4_third_accepted", 16'(done), 1);
        chk("t4_accept_cycle", 16'(k), 3);
        clear_inputs();
        for (int i = 0; i < 4; i++) step(aa, la);
        exp_ord = '{16'hA001, 16'hA002, 16'hA003};
        exp_dst = '{3'd4, 3'd6, 3'd7};
        foreach (commit_d[i]) if (commit_d[i] != 1) begin
            got_d.push_back(commit_d[i]); got_v.push_back(commit_v[i]);
        end
        chk("t4_load_count", 16'(got_v.size()), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t4_order_data", (i < got_v.size()) ? got_v[i] : 16'h0000, exp_ord[i]);
            chk("t4_order_dest", (i < got_d.size()) ? 16'(got_d[i]) : 16'h0000, 16'(exp_dst[i]));
        end

        // 5: write to r0 is consumed but dropped
        alu_valid = 1; alu_dest = 0; alu_data = 16'hFFFF;
        #1;
        chk("t5_alu_ready", alu_ready, 1);
        step(aa, la);
        clear_inputs();
        rf_data_1 = 16'h0055; rf_data_2 = 16'h0066;
        #1;
        chk("t5_write_en", write_en, 0);
        chk("t5_fwd_data_1", fwd_data_1, 16'h0055);
        chk("t5_fwd_data_2", fwd_data_2, 16'h0066);

        // 6: load commit to r2 collides with a reissue of r2
        issue_ld = 1; issue_dest = 2;
        step(aa, la);
        clear_inputs();
        ld_valid = 1; ld_dest = 2; ld_data = 16'h2222;
        step(aa, la);
        clear_inputs();
        issue_ld = 1; issue_dest = 2;
        step(aa, la);
        clear_inputs();
        #1;
        chk("t6_pending", pending, 16'h0004);
        chk("t6_write_en", write_en, 1);
        chk("t6_write_dest", write_dest, 2);
        chk("t6_write_data", write_data, 16'h2222);
        ld_valid = 1; ld_dest = 2; ld_data = 16'h3333;
        step(aa, la);
        clear_inputs();
        step(aa, la);
        #1;
        chk("t6_pending_final", pending, 0);
        chk("t6_write_data_final", write_data, 16'h3333);

        // Randomized traffic against the model
        outq.delete();
        for (int c = 0; c < 600; c++) begin
            issue_ld = 0; issue_dest = 0;
            if ($urandom_range(0, 99) < 30) begin
                d = 3'($urandom_range(1, 7));
                if (!mpend[d]) begin issue_ld = 1; issue_dest = d; end
            end
            if (!ld_valid && outq.size() > 0 && $urandom_range(0, 99) < 50) begin
                ld_valid = 1; ld_dest = outq[0]; ld_data = 16'($urandom);
            end
            alu_valid = 0;
            if ($urandom_range(0, 99) < 60) begin
                for (int t = 0; t < 8 && !alu_valid; t++) begin
                    d = 3'($urandom_range(0, 7));
                    if (!mpend[d] && !(issue_ld && issue_dest == d)) begin
                        alu_valid = 1; alu_dest = d; alu_data = 16'($urandom);
                    end
                end
            end
            rd_addr_1 = 3'($urandom_range(0, 7)); rd_addr_2 = 3'($urandom_range(0, 7));
            rf_data_1 = 16'($urandom); rf_data_2 = 16'($urandom);
            step(aa, la);
            if (la) begin void'(outq.pop_front()); ld_valid = 0; end
            if (issue_ld) outq.push_back(issue_dest);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
